dcache_controller: RTL and testbench

//  Data-cache responder for the core's load/store control strobes (MemRead/MemWrite).

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_if.sv | 28 ++
 rtl/dcache_tag_array.sv | 50 +++++
 rtl/dcache_controller.sv | 167 ++++++++++++++++
 tb/tb_dcache_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
// Build option: DCACHE_STATS_EN adds hit/miss counters on the top module.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINES      = 32;
    localparam int DEF_LINE_WORDS = 4;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Byte-offset bits [1:0] are never part of the tag.
    function automatic int tag_w(input int addr_w, input int lines, input int line_words);
        return addr_w - idx_w(lines) - off_w(line_words) - 2;
    endfunction

    localparam int OFF_W = off_w(DEF_LINE_WORDS);
    localparam int IDX_W = idx_w(DEF_LINES);
    localparam int TAG_W = tag_w(DEF_ADDR_W, DEF_LINES, DEF_LINE_WORDS);

endpackage

// File: rtl/dcache_if.sv
// Core-side strobes and memory-side refill/write handshake of the data cache.
interface dcache_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                    cpu_read;
    logic                    cpu_write;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [31:0]             cpu_wdata;
    logic [31:0]             cpu_rdata;
    logic                    cpu_stall;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [31:0]             mem_wdata;
    logic [32*LINE_WORDS-1:0] mem_rdata;
    logic                    mem_ready;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_tag_array.sv
// Valid/tag/data storage for the data cache: combinational read, one clocked write
// port (whole-line refill or single-word update), valid bits cleared asynchronously.
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int LINES      = 32,
    parameter int LINE_WORDS = 4,
    parameter int TAG_BITS   = 23
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [idx_w(LINES)-1:0]      rd_idx,
    output logic                         rd_valid,
    output logic [TAG_BITS-1:0]          rd_tag,
    output logic [32*LINE_WORDS-1:0]     rd_line,
    input  logic                         wr_line_en,
    input  logic                         wr_word_en,
    input  logic [idx_w(LINES)-1:0]      wr_idx,
    input  logic [off_w(LINE_WORDS)-1:0] wr_off,
    input  logic [TAG_BITS-1:0]          wr_tag,
    input  logic [32*LINE_WORDS-1:0]     wr_line_data,
    input  logic [31:0]                  wr_word_data
);
    logic [LINES-1:0]            valid_q;
    logic [TAG_BITS-1:0]         tag_mem  [LINES];
    logic [32*LINE_WORDS-1:0]    data_mem [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_line_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data contents are meaningless until the valid bit is set, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_line_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line_data;
        end else if (wr_word_en) begin
            data_mem[wr_idx][32*int'(wr_off) +: 32] <= wr_word_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Build option: DCACHE_STATS_EN adds stat_hits/stat_misses saturating counters.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINES      = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int OFF_BITS = off_w(LINE_WORDS);
    localparam int IDX_BITS = idx_w(LINES);
    localparam int TAG_BITS = tag_w(ADDR_W, LINES, LINE_WORDS);
    localparam int IDX_LO   = OFF_BITS + 2;
    localparam int TAG_LO   = IDX_BITS + OFF_BITS + 2;

    state_t                  state_q, state_d;
    logic                    mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [31:0]             mem_wdata_q;
    logic [OFF_BITS-1:0]     off_q;

    logic [OFF_BITS-1:0]     look_off;
    logic [IDX_BITS-1:0]     look_idx;
    logic [TAG_BITS-1:0]     look_tag;
    logic                    rd_valid;
    logic [TAG_BITS-1:0]     rd_tag;
    logic [32*LINE_WORDS-1:0] rd_line;
    logic                    hit;
    logic                    stall;
    logic [31:0]             rdata;
    logic                    wr_line_en, wr_word_en;

    // Idle lookups use the live core address; pending transactions use the latched one.
    always_comb begin
        look_off = bus.cpu_addr[IDX_LO-1:2];
        look_idx = bus.cpu_addr[TAG_LO-1:IDX_LO];
        look_tag = bus.cpu_addr[ADDR_W-1:TAG_LO];
        if (state_q != ST_IDLE) begin
            look_off = mem_addr_q[IDX_LO-1:2];
            look_idx = mem_addr_q[TAG_LO-1:IDX_LO];
            look_tag = mem_addr_q[ADDR_W-1:TAG_LO];
        end
    end

    dcache_tag_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_idx       (look_idx),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_line      (rd_line),
        .wr_line_en   (wr_line_en),
        .wr_word_en   (wr_word_en),
        .wr_idx       (mem_addr_q[TAG_LO-1:IDX_LO]),
        .wr_off       (mem_addr_q[IDX_LO-1:2]),
        .wr_tag       (mem_addr_q[ADDR_W-1:TAG_LO]),
        .wr_line_data (bus.mem_rdata),
        .wr_word_data (mem_wdata_q)
    );

    assign hit = rd_valid && (rd_tag == look_tag);

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        rdata      = '0;
        wr_line_en = 1'b0;
        wr_word_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_write) begin
                    stall   = 1'b1;
                    state_d = ST_WRITE;
                end else if (bus.cpu_read) begin
                    if (hit) begin
                        rdata = rd_line[32*int'(look_off) +: 32];
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                if (bus.mem_ready) begin
                    rdata      = bus.mem_rdata[32*int'(off_q) +: 32];
                    wr_line_en = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ready) begin
                    wr_word_en = hit;
                    state_d    = ST_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs are loaded on entry to a transaction and held until mem_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= MEM_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            off_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_REFILL) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= MEM_READ;
                mem_addr_q <= {bus.cpu_addr[ADDR_W-1:IDX_LO], {IDX_LO{1'b0}}};
                off_q      <= bus.cpu_addr[IDX_LO-1:2];
            end else if (state_q == ST_IDLE && state_d == ST_WRITE) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= MEM_WRITE;
                mem_addr_q  <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_q <= bus.cpu_wdata;
            end else if (state_q != ST_IDLE && state_d == ST_IDLE) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= MEM_READ;
            end
        end
    end

    assign bus.cpu_stall = stall;
    assign bus.cpu_rdata = rdata;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state_q == ST_IDLE && bus.cpu_read && !bus.cpu_write) begin
            if (hit && stat_hits != 32'hFFFF_FFFF) begin
                stat_hits <= stat_hits + 32'd1;
            end else if (!hit && stat_misses != 32'hFFFF_FFFF) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a hand-driven memory responder.
// Define DCACHE_STATS_EN to also check the hit/miss counters.
module tb_dcache_controller;

    localparam int ADDR_W     = 32;
    localparam int LINES      = 32;
    localparam int LINE_WORDS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_if #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS)) ifc ();

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    dcache_controller #(
        .ADDR_W     (ADDR_W),
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int checkCount = 0;
    int failCount  = 0;

    int          stalls;
    logic [31:0] rdata, addrSeen, wdataSeen;
    logic        reqSeen, weSeen;

    localparam logic [127:0] LINE_A = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    localparam logic [127:0] LINE_B = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};
    localparam logic [127:0] LINE_C = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'h1234_5678};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        ifc.cpu_read  = rd;
        ifc.cpu_write = wr;
        ifc.cpu_addr  = addr;
        ifc.cpu_wdata = wdata;
    endtask

    // Holds the core request until the stall clears; memory answers after lat cycles of mem_req.
    task automatic runAccess(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int lat, input logic [127:0] line);
        int  waited;
        bit  done;
        stalls = 0; waited = 0; done = 0;
        rdata = '0; reqSeen = 0; weSeen = 0; addrSeen = '0; wdataSeen = '0;
        applyStimulus(rd, wr, addr, wdata);
        ifc.mem_ready = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (ifc.mem_req) begin
                if (!reqSeen) begin
                    weSeen    = ifc.mem_we;
                    addrSeen  = ifc.mem_addr;
                    wdataSeen = ifc.mem_wdata;
                end
                reqSeen = 1'b1;
                waited++;
                if (waited >= lat) begin
                    ifc.mem_ready = 1'b1;
                    ifc.mem_rdata = line;
                end
            end
            @(negedge clk);
            if (ifc.cpu_stall) stalls++;
            else begin
                done  = 1'b1;
                rdata = ifc.cpu_rdata;
            end
            @(posedge clk);
            #1;
            ifc.mem_ready = 1'b0;
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput({tag, "_completed"}, 32'(done), 32'd1);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        ifc.mem_ready = 1'b0;
        ifc.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stall",     32'(ifc.cpu_stall), 32'd0);
        checkOutput("rst_mem_req",   32'(ifc.mem_req),   32'd0);
        checkOutput("rst_mem_we",    32'(ifc.mem_we),    32'd0);
        checkOutput("rst_mem_addr",  ifc.mem_addr,       32'h0);
        checkOutput("rst_mem_wdata", ifc.mem_wdata,      32'h0);
        checkOutput("rst_rdata",     ifc.cpu_rdata,      32'h0);
`ifdef DCACHE_STATS_EN
        checkOutput("rst_stat_hits",   stat_hits,   32'h0);
        checkOutput("rst_stat_misses", stat_misses, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] dcache_controller directed test start");
        resetDut();

        // Cold read miss with 3-cycle memory, then a hit on the neighbouring word.
        runAccess("t1_miss", 1'b1, 1'b0, 32'h40, 32'h0, 3, LINE_A);
        checkOutput("t1_miss_stalls", 32'(stalls),  32'd3);
        checkOutput("t1_miss_rdata",  rdata,        32'hD0D0_0000);
        checkOutput("t1_miss_req",    32'(reqSeen), 32'd1);
        checkOutput("t1_miss_we",     32'(weSeen),  32'd0);
        checkOutput("t1_miss_addr",   addrSeen,     32'h40);
        runAccess("t1_hit", 1'b1, 1'b0, 32'h44, 32'h0, 1, '0);
        checkOutput("t1_hit_stalls", 32'(stalls),  32'd0);
        checkOutput("t1_hit_rdata",  rdata,        32'hD1D1_0001);
        checkOutput("t1_hit_req",    32'(reqSeen), 32'd0);
`ifdef DCACHE_STATS_EN
        checkOutput("t6_stat_misses", stat_misses, 32'd1);
        checkOutput("t6_stat_hits",   stat_hits,   32'd1);
`endif

        // Store hit is written through and updates the resident word.
        runAccess("t2_store", 1'b0, 1'b1, 32'h44, 32'hCAFE_BABE, 2, '0);
        checkOutput("t2_store_stalls", 32'(stalls),  32'd2);
        checkOutput("t2_store_we",     32'(weSeen),  32'd1);
        checkOutput("t2_store_addr",   addrSeen,     32'h44);
        checkOutput("t2_store_wdata",  wdataSeen,    32'hCAFE_BABE);
        runAccess("t2_load", 1'b1, 1'b0, 32'h44, 32'h0, 1, '0);
        checkOutput("t2_load_rdata", rdata,        32'hCAFE_BABE);
        checkOutput("t2_load_req",   32'(reqSeen), 32'd0);
        runAccess("t2_other", 1'b1, 1'b0, 32'h40, 32'h0, 1, '0);
        checkOutput("t2_other_rdata", rdata, 32'hD0D0_0000);

        // Store miss does not allocate; the following load must refill.
        runAccess("t3_store", 1'b0, 1'b1, 32'h1000, 32'h1234_5678, 1, '0);
        checkOutput("t3_store_stalls", 32'(stalls), 32'd1);
        checkOutput("t3_store_we",     32'(weSeen), 32'd1);
        checkOutput("t3_store_addr",   addrSeen,    32'h1000);
        runAccess("t3_load", 1'b1, 1'b0, 32'h1000, 32'h0, 2, LINE_C);
        checkOutput("t3_load_req",    32'(reqSeen), 32'd1);
        checkOutput("t3_load_we",     32'(weSeen),  32'd0);
        checkOutput("t3_load_addr",   addrSeen,     32'h1000);
        checkOutput("t3_load_stalls", 32'(stalls),  32'd2);
        checkOutput("t3_load_rdata",  rdata,        32'h1234_5678);
        runAccess("t3_reload", 1'b1, 1'b0, 32'h100C, 32'h0, 1, '0);
        checkOutput("t3_reload_req",   32'(reqSeen), 32'd0);
        checkOutput("t3_reload_rdata", rdata,        32'hC3C3_0003);

        // Read and write together behave as a store.
        runAccess("rw_both", 1'b1, 1'b1, 32'h48, 32'h0BAD_F00D, 1, LINE_B);
        checkOutput("rw_both_we",   32'(weSeen), 32'd1);
        checkOutput("rw_both_addr", addrSeen,    32'h48);
        runAccess("rw_load", 1'b1, 1'b0, 32'h48, 32'h0, 1, '0);
        checkOutput("rw_load_rdata", rdata,        32'h0BAD_F00D);
        checkOutput("rw_load_req",   32'(reqSeen), 32'd0);

        // A stray mem_ready while idle is ignored.
        @(negedge clk);
        ifc.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.mem_ready = 1'b0;
        checkOutput("idle_ready_req", 32'(ifc.mem_req), 32'd0);
        runAccess("idle_ready_hit", 1'b1, 1'b0, 32'h40, 32'h0, 1, '0);
        checkOutput("idle_ready_hit_req", 32'(reqSeen), 32'd0);

        // Same-index conflict evicts unconditionally: three refills.
        resetDut();
        runAccess("t4_a1", 1'b1, 1'b0, 32'h40, 32'h0, 1, LINE_A);
        checkOutput("t4_a1_req",   32'(reqSeen), 32'd1);
        checkOutput("t4_a1_rdata", rdata,        32'hD0D0_0000);
        runAccess("t4_b", 1'b1, 1'b0, 32'h40 + LINES*16, 32'h0, 1, LINE_B);
        checkOutput("t4_b_req",   32'(reqSeen), 32'd1);
        checkOutput("t4_b_addr",  addrSeen,     32'h240);
        checkOutput("t4_b_rdata", rdata,        32'hB0B0_0000);
        runAccess("t4_a2", 1'b1, 1'b0, 32'h48, 32'h0, 1, LINE_A);
        checkOutput("t4_a2_req",   32'(reqSeen), 32'd1);
        checkOutput("t4_a2_rdata", rdata,        32'hD2D2_0002);

        // Reset in the middle of a refill drops mem_req at once and leaves the line invalid.
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("t5_req_before", 32'(ifc.mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_req_in_reset", 32'(ifc.mem_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runAccess("t5_load", 1'b1, 1'b0, 32'h40, 32'h0, 2, LINE_A);
        checkOutput("t5_load_req",   32'(reqSeen), 32'd1);
        checkOutput("t5_load_rdata", rdata,        32'hD0D0_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
